// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Holds the PC, drives the RAM instruction
//            port, pairs the registered RAM output with its address, and
//            delivers a valid-tagged instruction to decode. Decode stalls are
//            absorbed by a one-entry hold buffer; branch redirects cost one
//            bubble cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                       WIDTH         = 16,
  parameter int                       RAM_ADDR_BITS = 13,
  parameter logic [RAM_ADDR_BITS-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [RAM_ADDR_BITS-1:0] branch_target,
  output logic [RAM_ADDR_BITS-1:0] pcaddr,
  input  logic [WIDTH-1:0]         instruction,
  output logic [WIDTH-1:0]         instr_out,
  output logic [RAM_ADDR_BITS-1:0] instr_pc,
  output logic                     instr_valid,
  output logic [15:0]              fetch_count
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [RAM_ADDR_BITS-1:0] PC_ONE = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};

  state_t                     state_q,       state_d;
  logic [RAM_ADDR_BITS-1:0]   pc_q,          pc_d;
  logic [RAM_ADDR_BITS-1:0]   fpc_q,         fpc_d;
  logic                       fvalid_q,      fvalid_d;
  logic [WIDTH-1:0]           hold_instr_q,  hold_instr_d;
  logic [15:0]                fetch_count_q, fetch_count_d;

  // State register; reset takes effect immediately, independent of the clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      fpc_q         <= '0;
      fvalid_q      <= 1'b0;
      hold_instr_q  <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fpc_q         <= fpc_d;
      fvalid_q      <= fvalid_d;
      hold_instr_q  <= hold_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state logic: branch beats stall, stall beats advance.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fpc_d         = fpc_q;
    fvalid_d      = fvalid_q;
    hold_instr_d  = hold_instr_q;
    fetch_count_d = fetch_count_q;

    if (branch_taken) begin
      // Squash whatever is presented and restart fetch at the target.
      pc_d     = branch_target;
      fvalid_d = 1'b0;
      state_d  = RUN;
    end else if (stall) begin
      // The RAM keeps re-reading mem[pc], so the live word moves on to the
      // next instruction; capture the presented one the first stalled edge.
      if (state_q == RUN) begin
        hold_instr_d = instruction;
        state_d      = HOLD;
      end
    end else begin
      fpc_d    = pc_q;
      fvalid_d = 1'b1;
      pc_d     = pc_q + PC_ONE;
      state_d  = RUN;
      if (fvalid_q) begin
        fetch_count_d = fetch_count_q + 16'd1;
      end
    end
  end

  // Output mux: live RAM word in RUN, captured word while held.
  always_comb begin
    instr_out   = (state_q == HOLD) ? hold_instr_q : instruction;
    instr_pc    = fpc_q;
    instr_valid = fvalid_q;
    pcaddr      = pc_q;
    fetch_count = fetch_count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit with a RAM model, a
//            transaction-level reference model, directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int AB = 13;
  localparam int W  = 16;
  localparam logic [AB-1:0] WRAP_PC = 13'h1FFE;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [AB-1:0] branch_target = '0;

  logic [AB-1:0] pcaddr,      pcaddr_w;
  logic [W-1:0]  instruction, instruction_w;
  logic [W-1:0]  instr_out,   instr_out_w;
  logic [AB-1:0] instr_pc,    instr_pc_w;
  logic          instr_valid, instr_valid_w;
  logic [15:0]   fetch_count, fetch_count_w;

  logic [W-1:0]  mem [0:(1<<AB)-1];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what decode should currently see.
  logic          m_valid;
  logic [AB-1:0] m_pc;
  logic [AB-1:0] m_next;
  logic [15:0]   m_count;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(W), .RAM_ADDR_BITS(AB), .RESET_PC(13'h0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pcaddr(pcaddr), .instruction(instruction),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .fetch_count(fetch_count)
  );

  fetch_unit #(.WIDTH(W), .RAM_ADDR_BITS(AB), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pcaddr(pcaddr_w), .instruction(instruction_w),
    .instr_out(instr_out_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .fetch_count(fetch_count_w)
  );

  // Synchronous-read RAM ports, one per DUT.
  always @(posedge clk) begin
    instruction   <= mem[pcaddr];
    instruction_w <= mem[pcaddr_w];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: reset clears, branch opens a bubble, stall freezes, else the next
  // sequential address gets presented and the previous valid one counts.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0;
      m_pc    = '0;
      m_next  = '0;
      m_count = '0;
    end else if (branch_taken) begin
      m_valid = 1'b0;
      m_next  = branch_target;
    end else if (!stall) begin
      if (m_valid) m_count = m_count + 16'd1;
      m_pc    = m_next;
      m_valid = 1'b1;
      m_next  = m_next + 13'd1;
    end
  end

  // Every-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_ipc",   {19'd0, instr_pc},    32'd0);
      chk("rst_count", {16'd0, fetch_count}, 32'd0);
      chk("rst_pcaddr",{19'd0, pcaddr},      32'd0);
    end else begin
      chk("pcaddr", {19'd0, pcaddr},      {19'd0, m_next});
      chk("valid",  {31'd0, instr_valid}, {31'd0, m_valid});
      chk("count",  {16'd0, fetch_count}, {16'd0, m_count});
      if (m_valid) begin
        chk("ipc",   {19'd0, instr_pc},  {19'd0, m_pc});
        chk("instr", {16'd0, instr_out}, {16'd0, mem[m_pc]});
      end
    end
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic s, input logic b, input logic [AB-1:0] t);
    stall = s;
    branch_taken = b;
    branch_target = t;
  endtask

  task automatic pin(input string tag, input logic [W-1:0] ins, input logic [AB-1:0] pc,
                     input logic v, input logic [15:0] cnt);
    chk({tag, "_v"}, {31'd0, instr_valid}, {31'd0, v});
    chk({tag, "_c"}, {16'd0, fetch_count}, {16'd0, cnt});
    if (v) begin
      chk({tag, "_i"},  {16'd0, instr_out}, {16'd0, ins});
      chk({tag, "_pc"}, {19'd0, instr_pc},  {19'd0, pc});
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AB); i++) mem[i] = W'(16'h1000 + i);

    cyc(); cyc();
    chk("reset_pcaddr", {19'd0, pcaddr}, 32'd0);
    chk("reset_wrap_pcaddr", {19'd0, pcaddr_w}, {19'd0, WRAP_PC});
    reset = 1'b0;
    cyc(); pin("e1", 16'h1000, 13'd0, 1'b1, 16'd0);
    cyc(); pin("e2", 16'h1001, 13'd1, 1'b1, 16'd1);
    cyc(); pin("e3", 16'h1002, 13'd2, 1'b1, 16'd2);
    cyc(); pin("e4", 16'h1003, 13'd3, 1'b1, 16'd3);
    drv(1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      cyc(); pin("stall", 16'h1003, 13'd3, 1'b1, 16'd3);
    end
    drv(1'b0, 1'b0, '0);
    cyc(); pin("rel", 16'h1004, 13'd4, 1'b1, 16'd4);
    cyc(); pin("five", 16'h1005, 13'd5, 1'b1, 16'd5);
    drv(1'b0, 1'b1, 13'h0100);
    cyc(); pin("bubble", 16'h0000, 13'd0, 1'b0, 16'd5);
    drv(1'b0, 1'b0, '0);
    cyc(); pin("target", 16'h1100, 13'h0100, 1'b1, 16'd5);
    cyc(); pin("tgt1", 16'h1101, 13'h0101, 1'b1, 16'd6);
    drv(1'b1, 1'b0, '0);
    cyc(); pin("hold", 16'h1101, 13'h0101, 1'b1, 16'd6);
    drv(1'b1, 1'b1, 13'h0200);
    cyc(); pin("brstall", 16'h0000, 13'd0, 1'b0, 16'd6);
    drv(1'b0, 1'b0, '0);
    cyc(); pin("tgt2", 16'h1200, 13'h0200, 1'b1, 16'd6);
    cyc(); pin("tgt2n", 16'h1201, 13'h0201, 1'b1, 16'd7);
    drv(1'b1, 1'b0, '0);
    cyc(); pin("hold2", 16'h1201, 13'h0201, 1'b1, 16'd7);
    #1 reset = 1'b1;
    #1;
    chk("async_valid",  {31'd0, instr_valid}, 32'd0);
    chk("async_count",  {16'd0, fetch_count}, 32'd0);
    chk("async_pcaddr", {19'd0, pcaddr},      32'd0);
    drv(1'b0, 1'b0, '0);
    cyc();
    reset = 1'b0;
    cyc(); pin("restart", 16'h1000, 13'd0, 1'b1, 16'd0);
    chk("wrap0", {19'd0, instr_pc_w}, 32'h1FFE);
    chk("wrap0i", {16'd0, instr_out_w}, 32'h2FFE);
    cyc(); chk("wrap1", {19'd0, instr_pc_w}, 32'h1FFF);
    cyc(); chk("wrap2", {19'd0, instr_pc_w}, 32'h0000);
    chk("wrap2i", {16'd0, instr_out_w}, 32'h1000);
    cyc(); chk("wrap3", {19'd0, instr_pc_w}, 32'h0001);

    // Random phase; the model and the falling-edge compare do the checking.
    for (int n = 0; n < 3000; n++) begin
      drv(($urandom % 3) == 0, ($urandom % 8) == 0, AB'($urandom));
      if (($urandom % 250) == 0) reset = 1'b1;
      cyc();
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
